// File: rtl/ins_fetch_queue_pkg.sv
// Shared constants and entry types for the instruction fetch queue.
// Replaces the legacy riscv_defs.v defines (IFQ_NOP_INS, IFQ_STATE_RUN/HALT).
package ins_fetch_queue_pkg;

  localparam logic [31:0] IFQ_NOP_INS    = 32'h0000_0013;
  localparam logic [0:0]  IFQ_STATE_RUN  = 1'b0;
  localparam logic [0:0]  IFQ_STATE_HALT = 1'b1;

  typedef struct packed {
    logic [31:0] ins;
    logic        err;
  } ifq_ins_t;

  // A faulting fetch hands decode a harmless nop; the err flag carries the trap.
  function automatic ifq_ins_t ifq_make_ins(input logic [31:0] data, input logic err);
    ifq_make_ins.ins = err ? IFQ_NOP_INS : data;
    ifq_make_ins.err = err;
  endfunction

endpackage

// File: rtl/ins_fetch_queue_fifo.sv
// Synchronous FIFO for the fetch queue: push/pop/flush with fill count.
// Flush and push on the same edge leave exactly the pushed entry in the queue.
module ins_fetch_queue_fifo #(
  parameter int DATA_W = 65,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [DATA_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_addr;

  assign wr_addr   = flush ? '0 : wr_ptr;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= PTR_W'(push);
      fill   <= CNT_W'(push);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; readers qualify head_data with fill != 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= push_data;
  end

endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction prefetch queue: credit-based word fetch, in-order response buffering, jump flush.
// Optional macro IFQ_JUMP_ALIGN_CHECK_EN: misaligned jump targets raise a fault entry and halt fetching.
module ins_fetch_queue
  import ins_fetch_queue_pkg::*;
#(
  parameter int                C_XLEN         = 32,
  parameter int                C_FIFO_DEPTH   = 4,
  parameter logic [C_XLEN-1:0] C_RESET_VECTOR = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              ireqvalid_o,
  input  logic              ireqready_i,
  output logic [C_XLEN-1:0] ireqaddr_o,
  input  logic              irspvalid_i,
  input  logic [31:0]       irspdata_i,
  input  logic              irsperr_i,
  input  logic              jump_i,
  input  logic [C_XLEN-1:0] jump_addr_i,
  output logic              ins_valid_o,
  input  logic              ins_ready_i,
  output logic [31:0]       ins_o,
  output logic [C_XLEN-1:0] pc_o,
  output logic              ins_err_o
);

  localparam int CNT_W = $clog2(C_FIFO_DEPTH) + 1;

  typedef struct packed {
    ifq_ins_t          ins;
    logic [C_XLEN-1:0] pc;
  } entry_t;

  logic [CNT_W-1:0]  fill;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W:0]    in_use;
  logic [C_XLEN-1:0] pc_tag;
  logic [C_XLEN-1:0] jump_target;
  logic              running;
  logic              jump_misaligned;
  logic              req_fire;
  logic              rsp_keep;
  logic              fifo_push;
  logic              fifo_pop;
  entry_t            push_entry;
  entry_t            head_entry;

  assign jump_target = jump_addr_i & ~C_XLEN'(3);

`ifdef IFQ_JUMP_ALIGN_CHECK_EN
  logic [0:0] state;

  assign jump_misaligned = jump_i & (jump_addr_i[1:0] != 2'b00);
  assign running         = (state == IFQ_STATE_RUN);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     state <= IFQ_STATE_RUN;
    else if (jump_i) state <= jump_misaligned ? IFQ_STATE_HALT : IFQ_STATE_RUN;
  end
`else
  assign jump_misaligned = 1'b0;
  assign running         = 1'b1;
`endif

  // Every request in flight already owns a queue slot, so responses can never overflow.
  assign in_use          = {1'b0, fill} + {1'b0, outstanding};
  assign ireqvalid_o     = ~reset_i & running & ~jump_i & (in_use < (CNT_W+1)'(C_FIFO_DEPTH));
  assign req_fire        = ireqvalid_o & ireqready_i;
  assign rsp_keep        = irspvalid_i & ~jump_i & (discard == '0);
  assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(irspvalid_i);

  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    push_entry.ins = ifq_make_ins(irspdata_i, irsperr_i);
    push_entry.pc  = pc_tag;
    if (jump_misaligned) begin
      push_entry.ins = ifq_make_ins(32'h0, 1'b1);
      push_entry.pc  = jump_addr_i;
    end
  end

  assign fifo_push = rsp_keep | jump_misaligned;
  assign fifo_pop  = ins_valid_o & ins_ready_i;

  ins_fetch_queue_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (C_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (reset_i),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (jump_i),
    .head_data (head_entry),
    .fill      (fill)
  );

  // Responses still owed at a jump belong to the old stream and must be dropped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      outstanding <= '0;
      discard     <= '0;
      ireqaddr_o  <= C_RESET_VECTOR;
      pc_tag      <= C_RESET_VECTOR;
    end else begin
      outstanding <= outstanding_nxt;
      if (jump_i) begin
        discard    <= outstanding_nxt;
        ireqaddr_o <= jump_target;
        pc_tag     <= jump_target;
      end else begin
        if (irspvalid_i && (discard != '0)) discard <= discard - 1'b1;
        if (req_fire) ireqaddr_o <= ireqaddr_o + C_XLEN'(4);
        if (rsp_keep) pc_tag <= pc_tag + C_XLEN'(4);
      end
    end
  end

  assign ins_valid_o = (fill != '0);
  assign ins_o       = ins_valid_o ? head_entry.ins.ins : '0;
  assign ins_err_o   = ins_valid_o & head_entry.ins.err;
  assign pc_o        = ins_valid_o ? head_entry.pc : '0;

endmodule
